// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// with a settle timer that drops lock (and blocks reconfiguration) after every change.
module clk_en_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {ST_SETTLE, ST_LOCKED} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_locked;
  logic                r_ready;
  logic [ACC_W-1:0]    r_inc [NUM_CH];
  logic [ACC_W-1:0]    r_acc [NUM_CH];
  logic [NUM_CH-1:0]   r_ce;

  logic [ACC_W:0]      w_sum [NUM_CH];
  logic [NUM_CH-1:0]   w_sel;
  logic                w_accept;
  logic                w_hit;

  assign w_accept  = cfg_valid && r_ready;
  // An out-of-range channel matches no w_sel bit, so it is accepted but has no effect.
  assign w_hit     = |w_sel;
  assign cfg_ready = r_ready;
  assign locked    = r_locked;
  assign ce_out    = r_ce;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_sum[gi] = {1'b0, r_acc[gi]} + {1'b0, r_inc[gi]};
      assign w_sel[gi] = w_accept && (cfg_ch == CH_W'(gi));
    end
  endgenerate

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_inc[i] <= '0;
        r_acc[i] <= '0;
        r_ce[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_sel[i]) begin
          r_inc[i] <= cfg_inc;
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
        end else begin
          r_acc[i] <= w_sum[i][ACC_W-1:0];
          r_ce[i]  <= w_sum[i][ACC_W];
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || w_hit) begin
      r_state  <= ST_SETTLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
            r_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_LOCKED;
          r_locked <= 1'b1;
          r_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with NUM_CH=3, ACC_W=8, LOCK_CYCLES=4.
module tb_clk_en_gen;

  logic       refclk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [2:0] ce_out;
  logic       locked;

  int checks = 0;
  int errors = 0;

  clk_en_gen #(.NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4)) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .ce_out   (ce_out),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] inc);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_inc = inc;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_inc = '0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks += 3;
      if (ce_out !== 3'b000) begin errors++; $display("FAIL reset_ce cyc=%0d: got %b expected 000", i, ce_out); end
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked cyc=%0d: got %b expected 0", i, locked); end
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready cyc=%0d: got %b expected 0", i, cfg_ready); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks += 3;
      if (locked !== (k == 4)) begin errors++; $display("FAIL release_locked k=%0d: got %b expected %b", k, locked, (k == 4)); end
      if (cfg_ready !== (k == 4)) begin errors++; $display("FAIL release_ready k=%0d: got %b expected %b", k, cfg_ready, (k == 4)); end
      if (ce_out !== 3'b000) begin errors++; $display("FAIL release_ce k=%0d: got %b expected 000", k, ce_out); end
    end
  endtask

  task automatic test_rate();
    logic [2:0] exp_ce;
    do_reset();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rate_prelock: got %b expected 1", locked); end
    do_cfg(2'd0, 8'h40);
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL rate_lockdrop: got %b expected 0", locked); end
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rate_readydrop: got %b expected 0", cfg_ready); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ce = {2'b00, (k % 4 == 0)};
      checks += 2;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL rate_ce k=%0d: got %b expected %b", k, ce_out, exp_ce); end
      if (locked !== (k >= 4)) begin errors++; $display("FAIL rate_locked k=%0d: got %b expected %b", k, locked, (k >= 4)); end
    end
  endtask

  task automatic test_half();
    logic [2:0] exp_ce;
    do_reset();
    do_cfg(2'd2, 8'h80);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_ce = {(k % 2 == 0), 2'b00};
      checks++;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL half_ce k=%0d: got %b expected %b", k, ce_out, exp_ce); end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_ce;
    int nhigh;
    nhigh = 0;
    do_reset();
    do_cfg(2'd1, 8'hFF);
    for (int k = 1; k <= 520; k++) begin
      tick();
      exp_ce = {1'b0, (k % 256 != 1), 1'b0};
      checks++;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL wrap_ce k=%0d: got %b expected %b", k, ce_out, exp_ce); end
      if (k <= 256 && ce_out[1] === 1'b1) nhigh++;
    end
    checks++;
    if (nhigh != 255) begin errors++; $display("FAIL wrap_count: got %0d expected 255", nhigh); end
  endtask

  task automatic test_handshake();
    logic [2:0] exp_ce;
    logic       exp_lk;
    do_reset();
    do_cfg(2'd0, 8'h40);
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    cfg_inc = 8'h80;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) cfg_valid = 1'b0;
      exp_lk = (k == 4) || (k >= 9);
      exp_ce = {1'b0, (k >= 7) && (k % 2 == 1), (k % 4 == 0)};
      checks += 3;
      if (locked !== exp_lk) begin errors++; $display("FAIL hs_locked k=%0d: got %b expected %b", k, locked, exp_lk); end
      if (cfg_ready !== exp_lk) begin errors++; $display("FAIL hs_ready k=%0d: got %b expected %b", k, cfg_ready, exp_lk); end
      if (ce_out !== exp_ce) begin errors++; $display("FAIL hs_ce k=%0d: got %b expected %b", k, ce_out, exp_ce); end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] exp_ce;
    do_reset();
    do_cfg(2'd0, 8'h40);
    repeat (4) tick();
    do_cfg(2'd3, 8'h80);
    checks += 3;
    if (locked !== 1'b1) begin errors++; $display("FAIL inv_locked: got %b expected 1", locked); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL inv_ready: got %b expected 1", cfg_ready); end
    if (ce_out !== 3'b000) begin errors++; $display("FAIL inv_ce5: got %b expected 000", ce_out); end
    for (int k = 6; k <= 12; k++) begin
      tick();
      exp_ce = {2'b00, (k % 4 == 0)};
      checks += 2;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL inv_ce k=%0d: got %b expected %b", k, ce_out, exp_ce); end
      if (locked !== 1'b1) begin errors++; $display("FAIL inv_hold k=%0d: got %b expected 1", k, locked); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    rst = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_inc = 8'h80;
    tick();
    checks += 3;
    if (locked !== 1'b0) begin errors++; $display("FAIL coll_locked: got %b expected 0", locked); end
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b expected 0", cfg_ready); end
    if (ce_out !== 3'b000) begin errors++; $display("FAIL coll_ce: got %b expected 000", ce_out); end
    rst = 1'b0;
    cfg_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks += 2;
      if (ce_out !== 3'b000) begin errors++; $display("FAIL coll_after_ce k=%0d: got %b expected 000", k, ce_out); end
      if (locked !== (k >= 4)) begin errors++; $display("FAIL coll_after_locked k=%0d: got %b expected %b", k, locked, (k >= 4)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_cfg(2'd2, 8'hFF);
    repeat (3) tick();
    checks++;
    if (ce_out !== 3'b100) begin errors++; $display("FAIL mid_pre_ce: got %b expected 100", ce_out); end
    rst = 1'b1;
    tick();
    checks += 2;
    if (ce_out !== 3'b000) begin errors++; $display("FAIL mid_rst_ce: got %b expected 000", ce_out); end
    if (locked !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %b expected 0", locked); end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks += 2;
      if (ce_out !== 3'b000) begin errors++; $display("FAIL mid_after_ce k=%0d: got %b expected 000", k, ce_out); end
      if (locked !== (k == 4)) begin errors++; $display("FAIL mid_after_locked k=%0d: got %b expected %b", k, locked, (k == 4)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_inc = '0;
    test_reset();
    test_rate();
    test_half();
    test_wrap();
    test_handshake();
    test_invalid();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2: number of clock-enable channels, range 1..16.
REQ-002 SHALL provide parameter ACC_W, default 32: phase-accumulator and increment width, range 4..32.
REQ-003 SHALL provide parameter LOCK_CYCLES, default 1024: settle time in cycles, minimum 2.
REQ-004 SHALL define CH_W = max(1, clog2(NUM_CH)) as the cfg_ch width.
REQ-005 SHALL have port refclk, input, 1: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-007 SHALL have port cfg_valid, input, 1: configuration request.
REQ-008 SHALL have port cfg_ready, output, 1: configuration can be accepted.
REQ-009 SHALL have port cfg_ch, input, CH_W: target channel index.
REQ-010 SHALL have port cfg_inc, input, ACC_W: new increment; output rate = refclk*cfg_inc/2^ACC_W.
REQ-011 SHALL have port ce_out, output, NUM_CH: one-cycle clock-enable pulses, one bit per channel.
REQ-012 SHALL have port locked, output, 1: high when the configuration is stable and settled.

Function
REQ-013 SHALL implement a two-state FSM: SETTLE and LOCKED.
REQ-014 SHALL keep a settle counter of width clog2(LOCK_CYCLES)+1; in SETTLE it increments each cycle from 0.
REQ-015 SHALL move SETTLE->LOCKED on the edge where counter == LOCK_CYCLES-1, so locked rises exactly LOCK_CYCLES cycles after entering SETTLE.
REQ-016 SHALL register locked, driving it high only in LOCKED.
REQ-017 SHALL drive cfg_ready high only in LOCKED and low in SETTLE and during rst.
REQ-018 SHALL accept a configuration on the edge where cfg_valid && cfg_ready.
REQ-019 SHALL accept a valid channel (cfg_ch < NUM_CH) as follows, all on that same edge: inc[cfg_ch] <= cfg_inc, acc[cfg_ch] <= 0, ce_out[cfg_ch] <= 0, FSM -> SETTLE, counter <= 0.
REQ-020 SHALL accept a configuration with cfg_ch >= NUM_CH but discard it: no register change and no lock drop.
REQ-021 SHALL update every channel not being configured on every edge: {carry, acc} <= acc + inc at ACC_W+1 bits, so acc wraps modulo 2^ACC_W; ce_out[i] <= carry.
REQ-022 SHALL continue updating the channels in REQ-021 in both SETTLE and LOCKED; ce_out is not gated by locked.
REQ-023 SHALL produce no pulses on a channel with inc = 0: ce_out stays 0.
REQ-024 SHALL have latency such that after configuring inc = 2^(ACC_W-1), the first ce_out pulse occurs on the 2nd edge after acceptance and then repeats every 2 cycles.
REQ-025 SHALL never hold ce_out high for more than one consecutive cycle, except when inc >= 2^(ACC_W-1), where the pulse pattern follows REQ-021 exactly.
REQ-026 SHALL ignore cfg_valid while cfg_ready is low; the requester holds cfg_valid, cfg_ch and cfg_inc stable until acceptance.

Reset
REQ-027 SHALL, on any edge with rst = 1, set all inc and acc to 0, ce_out to 0, locked to 0, cfg_ready to 0, the FSM to SETTLE and the counter to 0.
REQ-028 SHALL give rst priority over a simultaneous cfg handshake; the configuration is lost.
REQ-029 SHALL, after rst deasserts, settle and raise locked after LOCK_CYCLES cycles with all channels idle (inc = 0).
REQ-030 SHALL apply the full reset of REQ-027 when rst asserts mid-SETTLE or mid-pulse train, with no residual pulse on the following cycle.

Verification
REQ-031 SHALL cover reset: ACC_W=8, LOCK_CYCLES=4, rst high 3 cycles then low -> ce_out=0, locked=0, cfg_ready=0 throughout; locked=1 and cfg_ready=1 on the 4th edge after release.
REQ-032 SHALL cover rate: configure ch0 inc=0x40 -> locked drops on the accept edge; ce_out[0] first high on the 4th edge, then every 4 cycles; ch1 stays 0.
REQ-033 SHALL cover wrap: ch1 inc=0xFF -> ce_out[1] high 255 of every 256 cycles; acc wraps without error.
REQ-034 SHALL cover the handshake: cfg_valid held during SETTLE -> not accepted until locked=1; accepted on the first edge with cfg_ready=1; SETTLE restarts.
REQ-035 SHALL cover an invalid channel: NUM_CH=3, cfg_ch=3 -> handshake completes, locked stays 1, all inc unchanged.
REQ-036 SHALL cover reset collision: rst=1 on the same edge as an accepted cfg -> inc stays 0, locked=0, no ce_out pulse afterward.
